// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with modulo terminal value, step size, wrap or
// saturate boundary mode, parallel load, sticky crossing flags and a crossing pulse.
module updown_counter_param #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 255,
    parameter int STEP_W   = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  count,
    output logic              wrap_pulse,
    output logic              ovf_sticky,
    output logic              udf_sticky,
    output logic              at_max,
    output logic              at_min
);

    // One extra bit so sums and the modulo correction never overflow.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_EXT = MAX_EXT + 1'b1;
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             pulse_q, pulse_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic [WIDTH:0] count_ext, step_ext, load_ext;
    logic [WIDTH:0] sum, sum_wrapped, diff, diff_wrapped;
    logic           cross_up, cross_dn;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        count_d      = count_q;
        pulse_d      = 1'b0;
        ovf_d        = ovf_q;
        udf_d        = udf_q;
        cross_up     = 1'b0;
        cross_dn     = 1'b0;
        count_ext    = {1'b0, count_q};
        step_ext     = (WIDTH+1)'(step);
        load_ext     = {1'b0, load_val};
        sum          = count_ext + step_ext;
        sum_wrapped  = sum - MOD_EXT;
        diff         = count_ext - step_ext;
        diff_wrapped = count_ext + MOD_EXT - step_ext;

        if (load) begin
            count_d = (load_ext > MAX_EXT) ? MAX_W : load_val;
        end else if (en) begin
            if (up) begin
                if (sum <= MAX_EXT) begin
                    count_d = sum[WIDTH-1:0];
                end else begin
                    cross_up = 1'b1;
                    count_d  = SATURATE ? MAX_W : sum_wrapped[WIDTH-1:0];
                end
            end else begin
                if (step_ext <= count_ext) begin
                    count_d = diff[WIDTH-1:0];
                end else begin
                    cross_dn = 1'b1;
                    count_d  = SATURATE ? '0 : diff_wrapped[WIDTH-1:0];
                end
            end
        end

        // A crossing in the same cycle as a clear wins, so set after clear.
        if (clr_flags) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (cross_up) ovf_d = 1'b1;
        if (cross_dn) udf_d = 1'b1;
        pulse_d = cross_up | cross_dn;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign count      = count_q;
    assign wrap_pulse = pulse_q;
    assign ovf_sticky = ovf_q;
    assign udf_sticky = udf_q;
    assign at_max     = (count_q == MAX_W);
    assign at_min     = (count_q == '0);

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised up/down counter: configurable width, modulo terminal value, step size and wrap/saturate mode.
- Adds parallel load, count enable, sticky overflow/underflow flags, a boundary-crossing pulse and max/min status.
- General-purpose event/position counter for datapath and control blocks; successor to the fixed 4-bit up/down counter.

Parameters:
- WIDTH, 8, count register width in bits.
- MAX_VAL, 255, terminal count value. Legal range is 1 to 2^WIDTH-1. Counter range is 0..MAX_VAL.
- STEP_W, 2, width of the step input. Constraint: 2^STEP_W-1 <= MAX_VAL.
- SATURATE, 0, boundary mode. 0 = wrap modulo MAX_VAL+1; 1 = clamp at 0 / MAX_VAL.

Ports:
- clk, in, 1, clock; all state updates on its rising edge.
- rst, in, 1, synchronous active-low reset.
- en, in, 1, count enable.
- up, in, 1, direction: 1 = increment, 0 = decrement.
- step, in, STEP_W, amount added or subtracted per enabled cycle.
- load, in, 1, parallel load strobe.
- load_val, in, WIDTH, parallel load value.
- clr_flags, in, 1, clears ovf_sticky and udf_sticky.
- count, out, WIDTH, registered count value.
- wrap_pulse, out, 1, registered one-cycle pulse on a boundary crossing.
- ovf_sticky, out, 1, an upward boundary crossing has occurred since the last clear.
- udf_sticky, out, 1, a downward boundary crossing has occurred since the last clear.
- at_max, out, 1, combinational: count == MAX_VAL.
- at_min, out, 1, combinational: count == 0.

Behaviour:
- Reset: clk rising edge with rst=0 forces count=0, wrap_pulse=0, ovf_sticky=0, udf_sticky=0. Reset overrides load, en and clr_flags in the same cycle. Reset mid-count discards all state.
- Update priority per edge: rst, then load, then en. With en=0 and load=0, count holds and wrap_pulse=0.
- Load:
  - count <= min(load_val, MAX_VAL); values above MAX_VAL are clamped.
  - wrap_pulse <= 0; sticky flags are unaffected by the load itself.
  - The load takes effect on the next edge (1-cycle latency).
- Enabled count with step=0: count holds, no crossing, wrap_pulse=0.
- Arithmetic: computed internally at WIDTH+1 bits so no intermediate overflow.
- Up, en=1:
  - sum = count + step.
  - If sum <= MAX_VAL: count <= sum.
  - Otherwise, crossing: SATURATE=0 gives count <= sum-(MAX_VAL+1); SATURATE=1 gives count <= MAX_VAL.
- Down, en=1:
  - If step <= count: count <= count - step.
  - Otherwise, crossing: SATURATE=0 gives count <= count+(MAX_VAL+1)-step; SATURATE=1 gives count <= 0.
- Crossing outputs:
  - wrap_pulse <= 1 for exactly one cycle, aligned with the updated count.
  - An up-crossing sets ovf_sticky; a down-crossing sets udf_sticky.
  - In saturate mode, a crossing is flagged every enabled cycle that would exceed the bound, including while already sitting at the bound.
- Flags:
  - clr_flags=1 clears both sticky flags on the next edge.
  - A set in the same cycle wins over clr_flags, so that flag stays 1.
- Status: at_max and at_min decode from the registered count with zero latency. With MAX_VAL >= 1, they are never both high.
- Inputs are sampled only at clk edges; no internal FSM beyond the count and flag registers.

Test Plan (WIDTH=4, MAX_VAL=9, STEP_W=2 unless noted):
1. Reset: rst=0 for 2 cycles with load=1, load_val=5 -> count=0, all flags 0, at_min=1. Then count to 6 and assert rst=0 -> count=0 on the next edge.
2. Wrap up (SATURATE=0): en=1, up=1, step=1 from 0 for 10 cycles -> count 1..9 then 0. wrap_pulse=1 only in the cycle count=0; ovf_sticky=1; at_max=1 when count=9.
3. Wrap down: load 1, then en=1, up=0, step=3 -> count=8, wrap_pulse=1, udf_sticky=1. Next cycle -> count=5, wrap_pulse=0.
4. Saturate (SATURATE=1): load 8, up step=3 -> count=9, ovf_sticky=1. Repeat -> count stays 9, wrap_pulse=1 each cycle. Down from 2 with step=3 -> count=0, udf_sticky=1.
5. Load priority and clamp: load=1, load_val=12, en=1, up=1 -> count=9 (clamped, no increment), wrap_pulse=0. load_val=4 -> count=4.
6. Flag race and hold: clr_flags=1 in the same cycle as an up-crossing -> ovf_sticky stays 1. Next cycle clr_flags=1 alone -> both flags 0. en=1, step=0 -> count unchanged, no pulse.
